// File: rtl/motion_ctrl.sv
// motion_ctrl: line-follower steering controller.
// Sequences the inner/mid/outer IR emitter pairs, converts each right/left
// sensor through the shared A2D, builds a weighted position error and runs a
// PI loop that produces signed 12-bit left/right motor duty commands.
// Optional feature: define MOTION_BRAKE_EN to abort a loop in progress and
// zero the motor commands as soon as go falls (default: go only sampled in IDLE).
module motion_ctrl #(
    parameter logic [13:0] PTERM   = 14'h3680,
    parameter logic [11:0] ITERM   = 12'h500,
    parameter logic [11:0] FWD_MAX = 12'h700
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [11:0] A2D_res,
    input  logic        cnv_cmplt,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic        IR_in_en,
    output logic        IR_mid_en,
    output logic        IR_out_en,
    output logic [11:0] lft_reg,
    output logic [11:0] rht_reg
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] SETTLE    = 4'd1;
    localparam logic [3:0] CNV_R     = 4'd2;
    localparam logic [3:0] WAIT32    = 4'd3;
    localparam logic [3:0] CNV_L     = 4'd4;
    localparam logic [3:0] INTG      = 4'd5;
    localparam logic [3:0] ICOMP     = 4'd6;
    localparam logic [3:0] PCOMP     = 4'd7;
    localparam logic [3:0] RIGHT_REG = 4'd8;
    localparam logic [3:0] LEFT_REG  = 4'd9;

    // Gains are unsigned; a zero sign bit lets them enter signed products.
    localparam logic signed [14:0] PTERM_S = {1'b0, PTERM};
    localparam logic signed [12:0] ITERM_S = {1'b0, ITERM};

    // Clamp a wide signed value into the 12-bit signed range [-2048, 2047].
    function automatic logic signed [11:0] sat12s(input logic signed [17:0] v);
        if (v > 18'sd2047)
            return 12'sh7FF;
        else if (v < -18'sd2048)
            return 12'sh800;
        else
            return v[11:0];
    endfunction

    // A2D channel of the right sensor for pair k (in, mid, out).
    function automatic logic [2:0] rht_chan(input logic [1:0] k);
        case (k)
            2'd0:    return 3'd1;
            2'd1:    return 3'd4;
            default: return 3'd3;
        endcase
    endfunction

    // A2D channel of the left sensor for pair k (in, mid, out).
    function automatic logic [2:0] lft_chan(input logic [1:0] k);
        case (k)
            2'd0:    return 3'd0;
            2'd1:    return 3'd2;
            default: return 3'd7;
        endcase
    endfunction

    logic [3:0]         state;
    logic [1:0]         pair;
    logic [11:0]        timer;
    logic [4:0]         wcnt;
    logic [1:0]         loop_cnt;
    logic [11:0]        fwd;
    logic signed [15:0] accum;
    logic signed [11:0] intgrl;
    logic signed [15:0] icomp;
    logic signed [15:0] pcomp;
    logic               dst2lft;

    logic signed [15:0] a2d_sh;
    logic signed [11:0] error;
    logic signed [11:0] err_div;
    logic signed [12:0] intg_sum;
    logic signed [11:0] intgrl_nxt;
    logic signed [24:0] iprod;
    logic signed [15:0] icomp_nxt;
    logic signed [26:0] pprod;
    logic signed [15:0] pcomp_nxt;
    logic signed [17:0] fwd_s;
    logic signed [17:0] rht_sum;
    logic signed [17:0] lft_sum;
    logic               ir_phase;

    // Emitter enables follow the active pair only while its sensors are in use.
    assign ir_phase  = (state == SETTLE) || (state == CNV_R) ||
                       (state == WAIT32) || (state == CNV_L);
    assign IR_in_en  = ir_phase && (pair == 2'd0);
    assign IR_mid_en = ir_phase && (pair == 2'd1);
    assign IR_out_en = ir_phase && (pair == 2'd2);

    // PI datapath: weighted sample, saturated error, integrator and P/I terms.
    always_comb begin
        a2d_sh     = {4'b0000, A2D_res} << pair;
        error      = sat12s(18'(accum));
        err_div    = error >>> 4;
        intg_sum   = 13'(intgrl) + 13'(err_div);
        intgrl_nxt = sat12s(18'(intg_sum));
        iprod      = 25'(intgrl) * 25'(ITERM_S);
        icomp_nxt  = 16'(iprod >>> 8);
        pprod      = 27'(error) * 27'(PTERM_S);
        pcomp_nxt  = 16'(pprod >>> 12);
        fwd_s      = {6'b000000, fwd};
        rht_sum    = fwd_s - 18'(pcomp) - 18'(icomp);
        lft_sum    = fwd_s + 18'(pcomp) + 18'(icomp);
    end

    // Loop sequencer: sensor scan, accumulation, PI update and motor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pair     <= 2'd0;
            timer    <= 12'd0;
            wcnt     <= 5'd0;
            loop_cnt <= 2'd0;
            fwd      <= 12'd0;
            accum    <= 16'sd0;
            intgrl   <= 12'sd0;
            icomp    <= 16'sd0;
            pcomp    <= 16'sd0;
            dst2lft  <= 1'b0;
            strt_cnv <= 1'b0;
            chnnl    <= 3'd0;
            lft_reg  <= 12'd0;
            rht_reg  <= 12'd0;
        end
`ifdef MOTION_BRAKE_EN
        else if (!go && (state != IDLE)) begin
            state    <= IDLE;
            pair     <= 2'd0;
            timer    <= 12'd0;
            wcnt     <= 5'd0;
            loop_cnt <= 2'd0;
            fwd      <= 12'd0;
            accum    <= 16'sd0;
            intgrl   <= 12'sd0;
            dst2lft  <= 1'b0;
            strt_cnv <= 1'b0;
            lft_reg  <= 12'd0;
            rht_reg  <= 12'd0;
        end
`endif
        else begin
            strt_cnv <= 1'b0;
            dst2lft  <= 1'b0;
            // The accumulator is emptied on the strobe that closes each loop.
            if (dst2lft)
                accum <= 16'sd0;
            case (state)
                IDLE: begin
                    if (go) begin
                        if (fwd < FWD_MAX)
                            fwd <= fwd + 12'd1;
                        pair  <= 2'd0;
                        timer <= 12'd0;
                        state <= SETTLE;
                    end else begin
                        fwd <= 12'd0;
                    end
                end
                SETTLE: begin
                    if (timer == 12'hFFF) begin
                        timer    <= 12'd0;
                        strt_cnv <= 1'b1;
                        chnnl    <= rht_chan(pair);
                        state    <= CNV_R;
                    end else begin
                        timer <= timer + 12'd1;
                    end
                end
                CNV_R: begin
                    // cnv_cmplt still shows the previous result during the start pulse.
                    if (!strt_cnv && cnv_cmplt) begin
                        accum <= accum + a2d_sh;
                        wcnt  <= 5'd0;
                        state <= WAIT32;
                    end
                end
                WAIT32: begin
                    if (wcnt == 5'd31) begin
                        wcnt     <= 5'd0;
                        strt_cnv <= 1'b1;
                        chnnl    <= lft_chan(pair);
                        state    <= CNV_L;
                    end else begin
                        wcnt <= wcnt + 5'd1;
                    end
                end
                CNV_L: begin
                    if (!strt_cnv && cnv_cmplt) begin
                        accum <= accum - a2d_sh;
                        if (pair == 2'd2) begin
                            state <= INTG;
                        end else begin
                            pair  <= pair + 2'd1;
                            timer <= 12'd0;
                            state <= SETTLE;
                        end
                    end
                end
                INTG: begin
                    // Integrator only updates on every fourth loop.
                    if (loop_cnt == 2'd3)
                        intgrl <= intgrl_nxt;
                    loop_cnt <= loop_cnt + 2'd1;
                    state    <= ICOMP;
                end
                ICOMP: begin
                    icomp <= icomp_nxt;
                    state <= PCOMP;
                end
                PCOMP: begin
                    pcomp <= pcomp_nxt;
                    state <= RIGHT_REG;
                end
                RIGHT_REG: begin
                    rht_reg <= sat12s(rht_sum);
                    state   <= LEFT_REG;
                end
                LEFT_REG: begin
                    lft_reg <= sat12s(lft_sum);
                    dst2lft <= 1'b1;
                    pair    <= 2'd0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_ctrl.sv
// tb_motion_ctrl: table-driven PI loop vectors with a scoreboard queue,
// an A2D behavioural responder, and hand sequences for timing and go-drop.
module tb_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [11:0] A2D_res;
    logic        cnv_cmplt;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        IR_in_en;
    logic        IR_mid_en;
    logic        IR_out_en;
    logic [11:0] lft_reg;
    logic [11:0] rht_reg;

    int checks = 0;
    int errors = 0;
    int n_strt = 0;
    bit a2d_busy = 1'b0;

    logic [11:0] rd [8];

    typedef struct {
        bit          do_rst;
        logic [11:0] r_in, r_mid, r_out, l_in, l_mid, l_out;
        logic [11:0] exp_lft, exp_rht;
    } vec_t;

    typedef struct {
        logic [11:0] lft;
        logic [11:0] rht;
    } exp_t;

    vec_t vecs [5];
    exp_t sb_q [$];

    motion_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .A2D_res   (A2D_res),
        .cnv_cmplt (cnv_cmplt),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .IR_in_en  (IR_in_en),
        .IR_mid_en (IR_mid_en),
        .IR_out_en (IR_out_en),
        .lft_reg   (lft_reg),
        .rht_reg   (rht_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // A2D responder: cnv_cmplt drops one clock after the start pulse, result a few clocks later.
    initial begin : a2d_model
        logic [2:0] ch;
        cnv_cmplt = 1'b1;
        A2D_res   = 12'h000;
        forever begin
            @(posedge clk); #1;
            if (strt_cnv === 1'b1) begin
                ch = chnnl;
                @(posedge clk); #1;
                cnv_cmplt = 1'b0;
                a2d_busy  = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                A2D_res   = rd[ch];
                cnv_cmplt = 1'b1;
                a2d_busy  = 1'b0;
            end
        end
    end

    // A new conversion must never be started while one is outstanding.
    always @(negedge clk) begin
        if (strt_cnv === 1'b1) begin
            n_strt++;
            chk("strt_while_busy", {31'd0, a2d_busy}, 32'd0);
        end
    end

    task automatic set_readings(input logic [11:0] ri, rm, ro, li, lm, lo);
        for (int c = 0; c < 8; c++) rd[c] = 12'h000;
        rd[1] = ri; rd[4] = rm; rd[3] = ro;
        rd[0] = li; rd[2] = lm; rd[7] = lo;
    endtask

    // Waits for the outer pair to finish, then for both motor registers to update.
    task automatic wait_loop_end(output bit ok);
        int n;
        n = 0;
        while (IR_out_en !== 1'b1 && n < 20000) begin @(posedge clk); #1; n++; end
        while (IR_out_en === 1'b1 && n < 20000) begin @(posedge clk); #1; n++; end
        ok = (n < 20000);
        repeat (6) @(posedge clk);
        #1;
    endtask

    // First pair: enable pattern, settle length, right/left channel and 32-clock gap.
    task automatic first_pair_timing();
        int n;
        n = 0;
        while (IR_in_en !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        chk("ir_in_only", {29'd0, IR_in_en, IR_mid_en, IR_out_en}, 32'h4);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (strt_cnv !== 1'b1 && n < 5000);
        chk("settle_len", n, 4096);
        chk("chnnl_right_in", chnnl, 3'd1);
        n = 0;
        while (cnv_cmplt === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        while (cnv_cmplt !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("a2d_resp_seen", {31'd0, cnv_cmplt}, 32'd1);
        @(posedge clk);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (strt_cnv !== 1'b1 && n < 100);
        chk("wait32_len", n, 32);
        chk("chnnl_left_in", chnnl, 3'd0);
    endtask

    initial begin : main
        bit   ok;
        exp_t e;
        int   s0;

        vecs[0] = '{1'b0, 12'h200, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h6D1, 12'h931};
        vecs[1] = '{1'b0, 12'h200, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h6D2, 12'h932};
        vecs[2] = '{1'b0, 12'h200, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h6D3, 12'h933};
        vecs[3] = '{1'b0, 12'h200, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h774, 12'h894};
        vecs[4] = '{1'b1, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h7FF, 12'h800};

        for (int c = 0; c < 8; c++) rd[c] = 12'h000;
        rst = 1'b1;
        go  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lft", lft_reg, 12'h000);
        chk("rst_rht", rht_reg, 12'h000);
        chk("rst_strt", {31'd0, strt_cnv}, 32'd0);
        chk("rst_chnnl", chnnl, 3'd0);
        chk("rst_ir", {29'd0, IR_in_en, IR_mid_en, IR_out_en}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_rst) begin
                go  = 1'b0;
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
            end
            set_readings(vecs[i].r_in, vecs[i].r_mid, vecs[i].r_out,
                         vecs[i].l_in, vecs[i].l_mid, vecs[i].l_out);
            sb_q.push_back('{lft: vecs[i].exp_lft, rht: vecs[i].exp_rht});
            go = 1'b1;
            if (i == 0) first_pair_timing();
            wait_loop_end(ok);
            chk($sformatf("loop_done_v%0d", i), {31'd0, ok}, 32'd1);
            e = sb_q.pop_front();
            chk($sformatf("lft_v%0d", i), lft_reg, e.lft);
            chk($sformatf("rht_v%0d", i), rht_reg, e.rht);
        end

        // go falls during the mid-pair settle of the next loop (all readings equal).
        set_readings(12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100);
        s0 = 0;
        while (IR_mid_en !== 1'b1 && s0 < 20000) begin @(posedge clk); #1; s0++; end
        chk("mid_pair_reached", {31'd0, IR_mid_en}, 32'd1);
        repeat (100) @(posedge clk);
        #1;
        go = 1'b0;
        s0 = n_strt;
        @(posedge clk); #1;
`ifdef MOTION_BRAKE_EN
        chk("brake_ir", {29'd0, IR_in_en, IR_mid_en, IR_out_en}, 32'd0);
        chk("brake_lft", lft_reg, 12'h000);
        chk("brake_rht", rht_reg, 12'h000);
        repeat (300) @(posedge clk);
        #1;
        chk("brake_no_strt", n_strt, s0);
        chk("brake_hold_lft", lft_reg, 12'h000);
`else
        chk("nobrake_ir_mid", {29'd0, IR_in_en, IR_mid_en, IR_out_en}, 32'h2);
        sb_q.push_back('{lft: 12'h002, rht: 12'h002});
        wait_loop_end(ok);
        chk("loop_done_nobrake", {31'd0, ok}, 32'd1);
        e = sb_q.pop_front();
        chk("lft_nobrake", lft_reg, e.lft);
        chk("rht_nobrake", rht_reg, e.rht);
        s0 = n_strt;
        repeat (300) @(posedge clk);
        #1;
        chk("hold_no_strt", n_strt, s0);
        chk("hold_ir", {29'd0, IR_in_en, IR_mid_en, IR_out_en}, 32'd0);
        chk("hold_lft", lft_reg, 12'h002);
        chk("hold_rht", rht_reg, 12'h002);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
